// File: rtl/mpmc11_pkg.sv
// Shared constants and types for the mpmc11 application-interface responder.
// Holds the app command encodings, the calibration length and the init FSM states.
package mpmc11_pkg;

  localparam logic [2:0] APP_CMD_WR = 3'b000;
  localparam logic [2:0] APP_CMD_RD = 3'b001;

  localparam int CALIB_CYCLES = 16;

  typedef enum logic {
    ST_CALIB,
    ST_RUN
  } init_state_t;

endpackage

// File: rtl/mpmc11_app_fifo.sv
// Show-ahead synchronous FIFO used for both the command queue and the write-data queue.
// pop_data always presents the head entry; full/empty/count come from the registered count.
module mpmc11_app_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             push_data,
  input  logic                         pop,
  output logic [WIDTH-1:0]             pop_data,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH):0]       count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] store [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = store[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is left unreset; only the pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mpmc11_app_responder.sv
// Behavioural MIG-style app-interface responder: calibration emulation, command and write-data
// queues, byte-masked backing store and a fixed-latency read pipeline. Optional MPMC11_APP_RDY_THROTTLE_EN.
module mpmc11_app_responder
  import mpmc11_pkg::*;
#(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128,
  parameter int MEM_WORDS  = 1024,
  parameter int RD_LATENCY = 8,
  parameter int CMDQ_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    app_en,
  input  logic [2:0]              app_cmd,
  input  logic [ADDR_WIDTH-1:0]   app_addr,
  output logic                    app_rdy,
  input  logic                    app_wdf_wren,
  input  logic [DATA_WIDTH-1:0]   app_wdf_data,
  input  logic [DATA_WIDTH/8-1:0] app_wdf_mask,
  input  logic                    app_wdf_end,
  output logic                    app_wdf_rdy,
  output logic [DATA_WIDTH-1:0]   app_rd_data,
  output logic                    app_rd_data_valid,
  output logic                    app_rd_data_end,
  output logic                    init_calib_complete
);

  localparam int MASK_W = DATA_WIDTH / 8;
  localparam int CMD_W  = 3 + ADDR_WIDTH;
  localparam int WD_W   = DATA_WIDTH + MASK_W;
  localparam int CNT_W  = $clog2(CMDQ_DEPTH) + 1;
  localparam int IDX_W  = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  init_state_t             state;
  logic [4:0]              calib_cnt;
  logic                    run;
  logic                    cmd_gate;
  logic                    wd_gate;
  logic                    cmd_full, cmd_empty, wd_full, wd_empty;
  logic [CNT_W-1:0]        cmd_count, wd_count;
  logic [CMD_W-1:0]        cmd_head;
  logic [WD_W-1:0]         wd_head;
  logic [2:0]              head_cmd;
  logic [ADDR_WIDTH-1:0]   head_addr;
  logic [IDX_W-1:0]        head_idx;
  logic [DATA_WIDTH-1:0]   wd_data;
  logic [MASK_W-1:0]       wd_mask;
  logic                    retire, do_write, do_read;
  logic                    unused_wdf_end;

  logic [DATA_WIDTH-1:0]   mem [MEM_WORDS];
  logic [RD_LATENCY-1:0]   rd_vld;
  logic [DATA_WIDTH-1:0]   rd_dat [RD_LATENCY];

  assign unused_wdf_end = app_wdf_end;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_CALIB;
      calib_cnt <= '0;
    end else if (state == ST_CALIB) begin
      if (calib_cnt == 5'(CALIB_CYCLES - 1)) state <= ST_RUN;
      else                                   calib_cnt <= calib_cnt + 5'd1;
    end
  end

  assign run                 = (state == ST_RUN);
  assign init_calib_complete = run;

`ifdef MPMC11_APP_RDY_THROTTLE_EN
  // Fibonacci LFSR x^16+x^14+x^13+x^11+1; each ready drops when its two bits are both zero.
  logic [15:0] lfsr;
  always_ff @(posedge clk) begin
    if (rst) lfsr <= 16'hACE1;
    else     lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end
  assign cmd_gate = |lfsr[1:0];
  assign wd_gate  = |lfsr[3:2];
`else
  assign cmd_gate = 1'b1;
  assign wd_gate  = 1'b1;
`endif

  assign app_rdy     = run && !cmd_full && cmd_gate;
  assign app_wdf_rdy = run && !wd_full && wd_gate;

  mpmc11_app_fifo #(.WIDTH(CMD_W), .DEPTH(CMDQ_DEPTH)) u_cmdq (
    .clk       (clk),
    .rst       (rst),
    .push      (app_en && app_rdy),
    .push_data ({app_cmd, app_addr}),
    .pop       (retire),
    .pop_data  (cmd_head),
    .full      (cmd_full),
    .empty     (cmd_empty),
    .count     (cmd_count)
  );

  mpmc11_app_fifo #(.WIDTH(WD_W), .DEPTH(CMDQ_DEPTH)) u_wdq (
    .clk       (clk),
    .rst       (rst),
    .push      (app_wdf_wren && app_wdf_rdy),
    .push_data ({app_wdf_data, app_wdf_mask}),
    .pop       (do_write),
    .pop_data  (wd_head),
    .full      (wd_full),
    .empty     (wd_empty),
    .count     (wd_count)
  );

  assert property (@(posedge clk) disable iff (rst)
    (cmd_count <= CNT_W'(CMDQ_DEPTH)) && (wd_count <= CNT_W'(CMDQ_DEPTH)));

  // A head write without its data beat blocks everything behind it to keep strict ordering.
  assign head_cmd  = cmd_head[CMD_W-1 -: 3];
  assign head_addr = cmd_head[ADDR_WIDTH-1:0];
  assign head_idx  = IDX_W'((head_addr >> 3) % ADDR_WIDTH'(MEM_WORDS));
  assign wd_data   = wd_head[WD_W-1 -: DATA_WIDTH];
  assign wd_mask   = wd_head[MASK_W-1:0];
  assign retire    = !cmd_empty && ((head_cmd != APP_CMD_WR) || !wd_empty);
  assign do_write  = retire && (head_cmd == APP_CMD_WR);
  assign do_read   = retire && (head_cmd == APP_CMD_RD);

  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int b = 0; b < MASK_W; b++) begin
        if (!wd_mask[b]) mem[head_idx][b*8 +: 8] <= wd_data[b*8 +: 8];
      end
    end
  end

  // Stages only load on a valid input, so the last stage holds the most recent read data.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_vld <= '0;
      for (int i = 0; i < RD_LATENCY; i++) rd_dat[i] <= '0;
    end else begin
      rd_vld[0] <= do_read;
      if (do_read) rd_dat[0] <= mem[head_idx];
      for (int i = 1; i < RD_LATENCY; i++) begin
        rd_vld[i] <= rd_vld[i-1];
        if (rd_vld[i-1]) rd_dat[i] <= rd_dat[i-1];
      end
    end
  end

  assign app_rd_data       = rd_dat[RD_LATENCY-1];
  assign app_rd_data_valid = rd_vld[RD_LATENCY-1];
  assign app_rd_data_end   = rd_vld[RD_LATENCY-1];

endmodule
